// File: rtl/button_step_counter_pkg.sv
// Shared types and elaboration-time helpers for the debounced up/down step counter.
package button_step_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } hold_state_t;

    // Number of bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int tick_cnt_width(input int clk_hz, input int tick_hz);
        int w;
        w = clog2(tick_div(clk_hz, tick_hz));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_step_counter_if.sv
// Button inputs and counter/LED/debug outputs of the step counter, bundled for port use.
interface button_step_counter_if #(
    parameter int WIDTH = 8
);
    logic             btn_up_n;
    logic             btn_down_n;
    logic             btn_clr_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] led;
    logic             tick;
    logic             step;

    modport master (
        output btn_up_n, btn_down_n, btn_clr_n,
        input  count, led, tick, step
    );

    modport slave (
        input  btn_up_n, btn_down_n, btn_clr_n,
        output count, led, tick, step
    );
endinterface

// File: rtl/button_step_counter_hold_repeat_fsm.sv
// Per-button press/hold/auto-repeat state machine, advanced only on sampling ticks.
module hold_repeat_fsm
    import button_step_counter_pkg::*;
#(
    parameter int REPEAT_DELAY = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_pressed,
    output logic o_req
);
    localparam int HOLD_W = clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY);

    hold_state_t       r_state;
    logic [HOLD_W-1:0] r_hold;

    // The request is combinational so the count moves on the edge that ends the tick cycle.
    assign o_req = i_tick & i_pressed & ((r_state == ST_IDLE) || (r_state == ST_REPEAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else if (i_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_pressed) begin
                        r_state <= ST_HOLD;
                        r_hold  <= HOLD_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!i_pressed) begin
                        r_state <= ST_IDLE;
                        r_hold  <= '0;
                    end else if (r_hold == HOLD_LAST) begin
                        r_state <= ST_REPEAT;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!i_pressed) begin
                        r_state <= ST_IDLE;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/button_step_counter.sv
// Up/down/clear push-button counter with tick-sampled debounce, hold-to-repeat and active-low LEDs.
module button_step_counter
    import button_step_counter_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 12,
    parameter int WIDTH        = 8,
    parameter int REPEAT_DELAY = 7,
    parameter int SATURATE     = 0
) (
    input  logic                  clk_50mhz,
    input  logic                  rst,
    button_step_counter_if.slave  bus
);
    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int DIV_W    = tick_cnt_width(CLK_HZ, TICK_HZ);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [2:0]       r_sync_meta;
    logic [2:0]       r_sync;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_step;
    logic             w_up_pressed;
    logic             w_dn_pressed;
    logic             w_clr_pressed;
    logic             w_req_up;
    logic             w_req_dn;

    // Bit order {clear, down, up}; released (1) is the idle value.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 3'b111;
            r_sync      <= 3'b111;
        end else begin
            r_sync_meta <= {bus.btn_clr_n, bus.btn_down_n, bus.btn_up_n};
            r_sync      <= r_sync_meta;
        end
    end

    assign w_up_pressed  = ~r_sync[0];
    assign w_dn_pressed  = ~r_sync[1];
    assign w_clr_pressed = ~r_sync[2];

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    hold_repeat_fsm #(.REPEAT_DELAY(REPEAT_DELAY)) u_up_fsm (
        .clk       (clk_50mhz),
        .rst       (rst),
        .i_tick    (r_tick),
        .i_pressed (w_up_pressed),
        .o_req     (w_req_up)
    );

    hold_repeat_fsm #(.REPEAT_DELAY(REPEAT_DELAY)) u_dn_fsm (
        .clk       (clk_50mhz),
        .rst       (rst),
        .i_tick    (r_tick),
        .i_pressed (w_dn_pressed),
        .o_req     (w_req_dn)
    );

    // Clear beats everything; opposing requests cancel; a clamped request leaves the count alone.
    always_comb begin
        w_count_next = r_count;
        if (r_tick && w_clr_pressed) begin
            w_count_next = '0;
        end else if (w_req_up && !w_req_dn) begin
            if (!((SATURATE != 0) && (r_count == CNT_MAX))) begin
                w_count_next = r_count + 1'b1;
            end
        end else if (w_req_dn && !w_req_up) begin
            if (!((SATURATE != 0) && (r_count == '0))) begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_step  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_step  <= (w_count_next != r_count);
        end
    end

    assign bus.count = r_count;
    assign bus.led   = ~r_count;
    assign bus.tick  = r_tick;
    assign bus.step  = r_step;
endmodule

// File: tb/tb_button_step_counter.sv
// Drives a wrapping and a saturating counter with identical button stimulus and checks both against a tick-level model.
module tb_button_step_counter;
    localparam int W  = 4;
    localparam int RD = 3;
    localparam int MAXV = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_step_counter_if #(.WIDTH(W)) bus0 ();
    button_step_counter_if #(.WIDTH(W)) bus1 ();

    button_step_counter #(
        .CLK_HZ(16), .TICK_HZ(1), .WIDTH(W), .REPEAT_DELAY(RD), .SATURATE(0)
    ) u_wrap (
        .clk_50mhz (clk),
        .rst       (rst),
        .bus       (bus0)
    );

    button_step_counter #(
        .CLK_HZ(16), .TICK_HZ(1), .WIDTH(W), .REPEAT_DELAY(RD), .SATURATE(1)
    ) u_sat (
        .clk_50mhz (clk),
        .rst       (rst),
        .bus       (bus1)
    );

    int checks = 0;
    int errors = 0;
    int m_cnt [2];
    int held_up = 0;
    int held_dn = 0;

    // Reference rule: a held button steps on its first sampled tick and on every
    // tick from the (REPEAT_DELAY+2)-th consecutive pressed sample onward.
    function automatic bit wants_step(input int held);
        return (held == 1) || (held >= RD + 2);
    endfunction

    function automatic int next_count(input int c, input bit ru, input bit rd, input bit clr, input bit sat);
        if (clr) return 0;
        if (ru == rd) return c;
        if (ru) return (c == MAXV) ? (sat ? MAXV : 0) : c + 1;
        return (c == 0) ? (sat ? 0 : MAXV) : c - 1;
    endfunction

    task automatic set_buttons(input bit up, input bit dn, input bit clr);
        bus0.btn_up_n   = ~up;
        bus0.btn_down_n = ~dn;
        bus0.btn_clr_n  = ~clr;
        bus1.btn_up_n   = ~up;
        bus1.btn_down_n = ~dn;
        bus1.btn_clr_n  = ~clr;
    endtask

    task automatic model_reset();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        held_up  = 0;
        held_dn  = 0;
    endtask

    // Applies a button pattern, waits for the next tick and checks the result one cycle later.
    task automatic do_tick(input bit up, input bit dn, input bit clr, input string tag);
        bit found;
        bit ru, rd;
        int old_c;
        bit exp_step [2];
        logic [W-1:0] got_cnt, got_led;
        logic got_step, got_tick;
        set_buttons(up, dn, clr);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus0.tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s tick_timeout: got no tick in 40 cycles, expected one every 16", tag);
            return;
        end
        checks++;
        if (bus1.tick !== 1'b1) begin
            errors++;
            $display("FAIL %s sat_tick_align: got %b expected 1", tag, bus1.tick);
        end
        held_up = up ? held_up + 1 : 0;
        held_dn = dn ? held_dn + 1 : 0;
        ru = up && wants_step(held_up);
        rd = dn && wants_step(held_dn);
        for (int d = 0; d < 2; d++) begin
            old_c       = m_cnt[d];
            m_cnt[d]    = next_count(old_c, ru, rd, clr, d == 1);
            exp_step[d] = (m_cnt[d] != old_c);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            got_cnt  = (d == 0) ? bus0.count : bus1.count;
            got_led  = (d == 0) ? bus0.led   : bus1.led;
            got_step = (d == 0) ? bus0.step  : bus1.step;
            got_tick = (d == 0) ? bus0.tick  : bus1.tick;
            checks++;
            if (got_cnt !== W'(m_cnt[d])) begin
                errors++;
                $display("FAIL %s count[dut%0d]: got %0d expected %0d", tag, d, got_cnt, m_cnt[d]);
            end
            checks++;
            if (got_led !== ~W'(m_cnt[d])) begin
                errors++;
                $display("FAIL %s led[dut%0d]: got %h expected %h", tag, d, got_led, ~W'(m_cnt[d]));
            end
            checks++;
            if (got_step !== exp_step[d]) begin
                errors++;
                $display("FAIL %s step[dut%0d]: got %b expected %b", tag, d, got_step, exp_step[d]);
            end
            checks++;
            if (got_tick !== 1'b0) begin
                errors++;
                $display("FAIL %s tick_width[dut%0d]: got %b expected 0", tag, d, got_tick);
            end
        end
        $display("tick %s up=%0d dn=%0d clr=%0d wrap_count=%0d sat_count=%0d", tag, up, dn, clr, m_cnt[0], m_cnt[1]);
    endtask

    task automatic test_reset();
        int first, ticks, last, bad_gap;
        bit saw_step, saw_nonzero;
        rst = 1'b1;
        set_buttons(0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.count !== 4'h0 || bus1.count !== 4'h0) begin
            errors++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", bus0.count, bus1.count);
        end
        checks++;
        if (bus0.led !== 4'hF || bus1.led !== 4'hF) begin
            errors++;
            $display("FAIL reset_led: got %h/%h expected f/f", bus0.led, bus1.led);
        end
        checks++;
        if (bus0.tick !== 1'b0 || bus0.step !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick_step: got tick=%b step=%b expected 0/0", bus0.tick, bus0.step);
        end
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus0.tick === 1'b1) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first != 16) begin
            errors++;
            $display("FAIL first_tick_latency: got %0d cycles expected 16", first);
        end
        ticks = 0; last = 0; bad_gap = 0; saw_step = 0; saw_nonzero = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus0.step !== 1'b0 || bus1.step !== 1'b0) saw_step = 1;
            if (bus0.count !== 4'h0 || bus1.count !== 4'h0) saw_nonzero = 1;
            if (bus0.tick === 1'b1) begin
                ticks++;
                if (i - last != 16) bad_gap = i - last;
                last = i;
            end
        end
        checks++;
        if (ticks != 6 || bad_gap != 0) begin
            errors++;
            $display("FAIL idle_tick_period: got %0d ticks (bad gap %0d) expected 6 ticks every 16", ticks, bad_gap);
        end
        checks++;
        if (saw_step) begin
            errors++;
            $display("FAIL idle_step: got a step pulse expected none");
        end
        checks++;
        if (saw_nonzero) begin
            errors++;
            $display("FAIL idle_count: got nonzero count expected 0");
        end
        $display("reset idle done ticks=%0d", ticks);
    endtask

    task automatic test_hold_repeat();
        for (int i = 0; i < 8; i++) do_tick(1, 0, 0, "hold_up");
        do_tick(0, 0, 0, "hold_release");
        checks++;
        if (bus0.count !== 4'd5 || bus0.led !== 4'hA) begin
            errors++;
            $display("FAIL hold_final: got count=%0d led=%h expected 5/a", bus0.count, bus0.led);
        end
    endtask

    task automatic test_wrap();
        do_tick(0, 0, 1, "wrap_clear");
        do_tick(0, 1, 0, "wrap_down_from_0");
        do_tick(0, 0, 0, "wrap_release");
        checks++;
        if (bus0.count !== 4'd15 || bus1.count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_low: got %0d/%0d expected 15/0", bus0.count, bus1.count);
        end
        do_tick(1, 0, 0, "wrap_up_from_15");
        do_tick(0, 0, 0, "wrap_release");
        do_tick(0, 1, 0, "wrap_down_from_0");
        do_tick(0, 0, 0, "wrap_release");
        checks++;
        if (bus0.count !== 4'd15) begin
            errors++;
            $display("FAIL wrap_final: got %0d expected 15", bus0.count);
        end
    endtask

    task automatic test_saturate();
        do_tick(0, 0, 1, "sat_clear");
        for (int i = 0; i < 6; i++) do_tick(0, 1, 0, "sat_hold_down");
        do_tick(0, 0, 0, "sat_release");
        checks++;
        if (bus1.count !== 4'd0 || bus0.count !== 4'd13) begin
            errors++;
            $display("FAIL sat_final: got sat=%0d wrap=%0d expected 0/13", bus1.count, bus0.count);
        end
    endtask

    task automatic test_simultaneous();
        do_tick(0, 0, 1, "sim_clear");
        for (int i = 0; i < 9; i++) begin
            do_tick(1, 0, 0, "sim_up");
            do_tick(0, 0, 0, "sim_release");
        end
        do_tick(1, 1, 0, "sim_up_down");
        do_tick(0, 0, 0, "sim_release");
        checks++;
        if (bus0.count !== 4'd9 || bus1.count !== 4'd9) begin
            errors++;
            $display("FAIL updown_cancel: got %0d/%0d expected 9/9", bus0.count, bus1.count);
        end
        do_tick(1, 0, 1, "sim_up_clear");
        do_tick(0, 0, 0, "sim_release");
        checks++;
        if (bus0.count !== 4'd0 || bus1.count !== 4'd0) begin
            errors++;
            $display("FAIL clear_priority: got %0d/%0d expected 0/0", bus0.count, bus1.count);
        end
    endtask

    task automatic test_reset_mid_repeat();
        do_tick(0, 0, 1, "rr_clear");
        for (int i = 0; i < 10; i++) do_tick(1, 0, 0, "rr_hold_up");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus0.count !== 4'd0 || bus1.count !== 4'd0 || bus0.led !== 4'hF || bus0.step !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d/%0d led=%h step=%b expected 0/0 f 0",
                     bus0.count, bus1.count, bus0.led, bus0.step);
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.step !== 1'b0 || bus1.step !== 1'b0) begin
            errors++;
            $display("FAIL release_step: got %b/%b expected 0/0", bus0.step, bus1.step);
        end
        for (int i = 0; i < 6; i++) do_tick(1, 0, 0, "rr_after_reset");
        do_tick(0, 0, 0, "rr_release");
        checks++;
        if (bus0.count !== 4'd3) begin
            errors++;
            $display("FAIL restart_repeat: got %0d expected 3", bus0.count);
        end
    endtask

    task automatic test_random();
        bit up, dn, clr;
        up = 0; dn = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) up = ~up;
            if ($urandom_range(0, 3) == 0) dn = ~dn;
            clr = ($urandom_range(0, 9) == 0);
            do_tick(up, dn, clr, "random");
        end
        do_tick(0, 0, 0, "random_release");
    endtask

    initial begin
        set_buttons(0, 0, 0);
        test_reset();
        test_hold_repeat();
        test_wrap();
        test_saturate();
        test_simultaneous();
        test_reset_mid_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_step_counter.md
Name: button_step_counter

Overview:
Parametrised successor to the single-button LED counter. Counts up or down from two active-low push-buttons, with a clear button, tick-sampled debouncing and hold-to-auto-repeat. Width, tick rate, repeat delay and wrap/saturate mode are configurable. Uses a synchronous tick-enable from a divider, not a derived clock, and drives the board LEDs directly; LEDs are active-low.

Parameters:
CLK_HZ, 50000000, input clock frequency
TICK_HZ, 12, button sampling / repeat rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2
WIDTH, 8, counter and LED width
REPEAT_DELAY, 7, ticks a button must be held after the first step before auto-repeat starts (>= 1)
SATURATE, 0, 0 = wrap at 0/max; 1 = clamp at 0 and 2^WIDTH-1

Ports:
clk_50mhz  in   1      system clock; one clock; reset is asynchronous and active-high
rst        in   1      asynchronous active-high reset
btn_up_n   in   1      increment button, asynchronous, 0 = pressed
btn_down_n in   1      decrement button, asynchronous, 0 = pressed
btn_clr_n  in   1      clear button, asynchronous, 0 = pressed
count      out  WIDTH  current count value
led        out  WIDTH  ~count (LED on = 0)
tick       out  1      one-cycle sampling strobe, for debug
step       out  1      one-cycle pulse in the cycle after count changes

Behaviour:
- Reset (async, rst=1): count=0, led=all ones, tick=0, step=0, divider=0, both FSMs IDLE, hold counters 0, synchronizer flops=1 (released).
- Each button passes through a 2-flop synchronizer. Buttons are only acted on when tick=1; the slow sample rate is the debounce.
- Divider: counts 0..TICK_DIV-1 and wraps. tick is registered high for exactly one cycle on the wrap, so the first tick occurs TICK_DIV cycles after reset release.
- Per-button FSM (up and down instances). Evaluated only on tick cycles; holds state otherwise.
  - IDLE: pressed -> request step, go HOLD, hold=1. Released -> stay.
  - HOLD: released -> IDLE, hold=0. Pressed and hold==REPEAT_DELAY -> REPEAT. Otherwise hold++.
  - REPEAT: pressed -> request step every tick. Released -> IDLE, hold=0.
  - hold counter width is clog2(REPEAT_DELAY+1); it never exceeds REPEAT_DELAY.
- Count update on a tick cycle, priority order:
  1. clear pressed -> count=0. Up/down requests are discarded; the FSMs still advance.
  2. up and down requests in the same tick -> no change.
  3. single request -> count +/- 1.
- Wrap/saturate rules:
  - SATURATE=0: max+1 -> 0 and 0-1 -> max.
  - SATURATE=1: clamp at the limit. A clamped request produces no count change and no step pulse.
- Latency: a request on tick cycle T updates count at the edge ending T, so the new value is visible at T+1. step=1 during T+1 only when the value actually changed; clear from 0 gives no pulse.
- Press-to-count latency: 2 sync cycles + wait for next tick + 1 cycle.
- Reset asserted mid-hold or mid-repeat returns everything to reset values immediately. No step is emitted on release of reset.

Decomposition:
- Shared package: FSM state enum (IDLE, HOLD, REPEAT); a function computing TICK_DIV and its counter width from CLK_HZ/TICK_HZ; clog2 helper.
- One sub-module, hold_repeat_fsm: synchronized button, tick and hold counter in; step request out. Instantiated twice, for up and down.
- Top level holds synchronizers, divider, arbitration, counter and LED inversion.

Test Plan:
Bench uses CLK_HZ=16, TICK_HZ=1 (TICK_DIV=16), WIDTH=4, REPEAT_DELAY=3.
1. Reset, then idle for 100 cycles -> count=0, led=4'hF, tick pulses every 16 cycles, step never asserts.
2. Hold btn_up_n=0 for 8 ticks -> count changes 1 at tick 1 and +1 per tick from tick 5. Final count=5, led=4'hA.
3. SATURATE=0, count=15, single up press (1 tick) -> count=0 with a step pulse. Then a down press -> count=15.
4. SATURATE=1, count=0, hold down for 6 ticks -> count stays 0, step never asserts.
5. count=9; press up and down together for 1 tick -> count stays 9. Then press up and clear together -> count=0.
6. Mid-REPEAT with count=7, assert rst for 3 cycles while the button stays held -> count=0 immediately. After release the FSM restarts from IDLE: first step at the next tick, repeat resumes 4 ticks later.
